udp_rx_payload_reader: RTL and testbench
========================================

# udp_rx_payload_reader

Receive-side counterpart of the UDP transmit controller. When `mac_top` flags a received UDP datagram, this block reads the payload out of `mac_top`'s receive RAM and writes it byte by byte into the downstream playback FIFO (audio DAC path). It sits between `mac_top`'s `udp_rec_*` ports and the FIFO write side. Everything runs in the `gmii_rx_clk` domain.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2048: depth of the downstream FIFO, in bytes.
- `MAX_PAYLOAD`, default 1472: largest payload accepted, in bytes.
- `ADDR_W`, default 11: width of the receive-RAM address.

Ports (clock and reset first):
- `gmii_rx_clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `udp_rec_data_valid`  in  1  one-cycle pulse: a datagram is complete in the receive RAM.
- `udp_rec_data_length`  in  16  UDP length field (8-byte header + payload); sampled on the valid pulse.
- `udp_rec_ram_read_addr`  out  ADDR_W  receive-RAM read address.
- `udp_rec_ram_rdata`  in  8  RAM read data; valid 1 cycle after the address.
- `fifo_wr_count`  in  $clog2(FIFO_DEPTH)+1  current FIFO fill level.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  8  FIFO write data.
- `busy`  out  1  high in every state except IDLE.
- `pkt_done`  out  1  one-cycle pulse when a packet has been fully written to the FIFO.
- `pkt_drop`  out  1  one-cycle pulse when a packet is discarded.
- `pkt_cnt`  out  16  packets delivered; wraps.
- `drop_cnt`  out  16  packets dropped; wraps.

## Operation
- **IDLE**: wait for `udp_rec_data_valid`. On the pulse, latch `len = udp_rec_data_length - 8` (16-bit) and go to CHECK.
- **CHECK** (1 cycle):
  - Drop if `udp_rec_data_length < 9`, if `len > MAX_PAYLOAD`, or if `FIFO_DEPTH - fifo_wr_count < len`.
  - Drop means: pulse `pkt_drop`, increment `drop_cnt`, return to IDLE.
  - Otherwise go to READ.
- **READ**:
  - Issue addresses 0 .. len-1, one per cycle.
  - A one-stage pipe flag marks each issued address; `fifo_wr_en` is that flag delayed 1 cycle, with `fifo_wr_data = udp_rec_ram_rdata`.
  - After the last address is issued, go to FLUSH.
- **FLUSH** (1 cycle): the last byte is written.
- **DONE** (1 cycle): pulse `pkt_done`, increment `pkt_cnt`, go to IDLE.
- A `udp_rec_data_valid` pulse arriving outside IDLE is ignored, and `drop_cnt` increments. `pkt_drop` does not pulse for this case.
- No backpressure exists during READ: the CHECK-stage space check is the only guarantee against FIFO overflow.
- `udp_rec_ram_read_addr` holds 0 while not in READ.

## Timing
- Reset values:
  - All outputs 0; state is IDLE.
  - All counters 0, including `seq_err_cnt` when it is compiled in.
- Let cycle 0 be the valid pulse, with N = len:
  - Cycle 1: CHECK.
  - Cycles 2 .. N+1: addresses 0 .. N-1.
  - Cycles 3 .. N+2: `fifo_wr_en` high, N consecutive cycles with no gaps.
  - Cycle N+3: `pkt_done`.
- The earliest next packet is accepted at cycle N+4.
- `pkt_drop` appears at cycle 2.
- Counters update on the same edge as their pulse.
- Reset asserted mid-packet: all outputs go low immediately; the partially written packet stays in the FIFO.

## Configuration
- Macro `UDP_RX_SEQ_CHECK_EN`.
- **Defined**:
  - The first two payload bytes are a big-endian 16-bit sequence number. They are read from the RAM but not written to the FIFO.
  - The space and minimum-length checks use `len - 2`.
  - A packet is dropped if `udp_rec_data_length < 11`.
  - The first packet after reset sets `expected = seq + 1`. For each later packet, a mismatch increments the extra output `seq_err_cnt` (16-bit, wraps), and `expected` is then resynchronised to `seq + 1`. Packets with a mismatch are still delivered.
  - FIFO writes run over cycles 5 .. N+2, i.e. N-2 bytes; `pkt_done` timing is unchanged.
- **Undefined**: the `seq_err_cnt` port does not exist, and every payload byte is forwarded.

## Structure
- Shared package `udp_rx_pkg` holds:
  - the state enum (IDLE, CHECK, READ, FLUSH, DONE);
  - `UDP_HDR_LEN = 8` and `SEQ_LEN = 2`;
  - the default value of `MAX_PAYLOAD`.
- Sub-module `udp_rx_seq_check`: captures the two sequence bytes, holds `expected` and `seq_err_cnt`. It is instantiated only under `UDP_RX_SEQ_CHECK_EN`.

## Test plan
- Length 108, FIFO empty -> 100 writes; RAM pattern addr[7:0] appears on `fifo_wr_data` as 0..99; `pkt_done` at cycle 103; `pkt_cnt` = 1.
- Length 1481 (payload 1473) -> `pkt_drop` at cycle 2, no writes, `drop_cnt` = 1. Length 8 -> drop.
- `fifo_wr_count` = 2000, length 108 (48 bytes free < 100) -> drop. Then `fifo_wr_count` = 1948, length 108 (exactly 100 free) -> delivered.
- Second valid pulse at cycle 50 of a 100-byte packet -> first packet delivered intact, `drop_cnt` = 1, no `pkt_drop` pulse.
- `rst` asserted at cycle 40 of a 100-byte packet -> `fifo_wr_en` low that cycle; next packet after release is delivered fully.
- (With `UDP_RX_SEQ_CHECK_EN`) sequence numbers 5, 6, 8, 9 with length 108 -> 98 bytes written per packet, `seq_err_cnt` = 1; sequence 0xFFFF followed by 0x0000 -> no error (wrap).

Source files
------------

// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive payload reader.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int UDP_HDR_LEN         = 8;
    localparam int SEQ_LEN             = 2;
    localparam int MAX_PAYLOAD_DEFAULT = 1472;

endpackage

// File: rtl/udp_rx_seq_check.sv
// Sequence-number tracker: assembles the big-endian 16-bit sequence number
// from the first two payload bytes and counts discontinuities.
// Only instantiated when UDP_RX_SEQ_CHECK_EN is defined.
module udp_rx_seq_check (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_stb,
    input  logic        lo_stb,
    input  logic [7:0]  rdata,
    output logic [15:0] seq_err_cnt
);

    logic [7:0]  hi_q;
    logic [15:0] expected_q;
    logic        synced_q;
    logic [15:0] seq;

    assign seq = {hi_q, rdata};

    // Capture the high byte, then compare on the low byte and resync expected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q        <= 8'd0;
            expected_q  <= 16'd0;
            synced_q    <= 1'b0;
            seq_err_cnt <= 16'd0;
        end else begin
            if (hi_stb) begin
                hi_q <= rdata;
            end
            if (lo_stb) begin
                if (synced_q && (seq != expected_q)) begin
                    seq_err_cnt <= seq_err_cnt + 16'd1;
                end
                expected_q <= seq + 16'd1;
                synced_q   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_rx_payload_reader.sv
// Reads a received UDP payload out of the MAC receive RAM and writes it
// byte by byte into the playback FIFO.
// Optional feature macro: UDP_RX_SEQ_CHECK_EN (strip and check a 16-bit
// big-endian sequence number at the start of each payload).
module udp_rx_payload_reader
    import udp_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2048,
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT,
    parameter int ADDR_W      = 11
) (
    input  logic                        gmii_rx_clk,
    input  logic                        rst,
    input  logic                        udp_rec_data_valid,
    input  logic [15:0]                 udp_rec_data_length,
    output logic [ADDR_W-1:0]           udp_rec_ram_read_addr,
    input  logic [7:0]                  udp_rec_ram_rdata,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_wr_count,
    output logic                        fifo_wr_en,
    output logic [7:0]                  fifo_wr_data,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        pkt_drop,
    output logic [15:0]                 pkt_cnt,
    output logic [15:0]                 drop_cnt
`ifdef UDP_RX_SEQ_CHECK_EN
    ,
    output logic [15:0]                 seq_err_cnt
`endif
);

    // Handshake: udp_rec_data_valid is a one-cycle pulse with no ready
    // return; it is accepted only in IDLE, otherwise counted as dropped.
    // The FIFO side has no backpressure; fifo_wr_en writes unconditionally.

`ifdef UDP_RX_SEQ_CHECK_EN
    localparam int SKIP = SEQ_LEN;
`else
    localparam int SKIP = 0;
`endif
    localparam logic [15:0] MIN_LEN = 16'(UDP_HDR_LEN + SKIP + 1);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic        short_q;
    logic [15:0] addr_q;
    logic        issue_q;
    logic        drop_now;
    logic        ignored;
    logic        too_long;
    logic        fits;
    logic [31:0] free_bytes;
    logic [31:0] need_bytes;
    logic        wr_gate;

    assign ignored = udp_rec_data_valid && (state_q != IDLE);

    // Admission checks evaluated while in CHECK: payload size and FIFO room.
    always_comb begin
        free_bytes = 32'd0;
        if (32'(fifo_wr_count) < 32'(FIFO_DEPTH)) begin
            free_bytes = 32'(FIFO_DEPTH) - 32'(fifo_wr_count);
        end
        need_bytes = 32'(len_q) - 32'(SKIP);
        fits       = (need_bytes <= free_bytes);
        too_long   = (32'(len_q) > 32'(MAX_PAYLOAD));
    end

    // State register.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d               = state_q;
        drop_now              = 1'b0;
        busy                  = (state_q != IDLE);
        pkt_done              = (state_q == DONE);
        udp_rec_ram_read_addr = '0;
        case (state_q)
            IDLE: begin
                if (udp_rec_data_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (short_q || too_long || !fits) begin
                    drop_now = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                udp_rec_ram_read_addr = addr_q[ADDR_W-1:0];
                if (addr_q == (len_q - 16'd1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Length latch, read address counter and the issued-address pipe flag.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            len_q   <= 16'd0;
            short_q <= 1'b0;
            addr_q  <= 16'd0;
            issue_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && udp_rec_data_valid) begin
                len_q   <= udp_rec_data_length - 16'(UDP_HDR_LEN);
                short_q <= (udp_rec_data_length < MIN_LEN);
            end
            if (state_q == READ) begin
                addr_q <= addr_q + 16'd1;
            end else begin
                addr_q <= 16'd0;
            end
            issue_q <= (state_q == READ);
        end
    end

    // Status pulses and wrapping packet counters.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            pkt_drop <= 1'b0;
            pkt_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            pkt_drop <= drop_now;
            if (state_q == FLUSH) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            drop_cnt <= drop_cnt + {15'd0, drop_now} + {15'd0, ignored};
        end
    end

`ifdef UDP_RX_SEQ_CHECK_EN
    logic hi_q;
    logic lo_q;

    // Mark the RAM data cycles that carry the two sequence-number bytes.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            hi_q <= (state_q == READ) && (addr_q == 16'd0);
            lo_q <= (state_q == READ) && (addr_q == 16'd1);
        end
    end

    assign wr_gate = issue_q && !(hi_q || lo_q);

    udp_rx_seq_check u_seq_check (
        .clk         (gmii_rx_clk),
        .rst         (rst),
        .hi_stb      (hi_q),
        .lo_stb      (lo_q),
        .rdata       (udp_rec_ram_rdata),
        .seq_err_cnt (seq_err_cnt)
    );
`else
    assign wr_gate = issue_q;
`endif

    assign fifo_wr_en   = wr_gate;
    assign fifo_wr_data = wr_gate ? udp_rec_ram_rdata : 8'd0;

endmodule

// File: tb/tb_udp_rx_payload_reader.sv
// Self-checking bench for udp_rx_payload_reader (default build and, when
// UDP_RX_SEQ_CHECK_EN is defined, the sequence-check build).
module tb_udp_rx_payload_reader;

    localparam int NC = 8192;
`ifdef UDP_RX_SEQ_CHECK_EN
    localparam int SKIP = 2;
    localparam int MINL = 11;
`else
    localparam int SKIP = 0;
    localparam int MINL = 9;
`endif
    localparam int EXP_N = 100 - SKIP;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] length;
    logic [10:0] addr;
    logic [7:0]  rdata;
    logic [11:0] count;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        pkt_done;
    logic        pkt_drop;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`ifdef UDP_RX_SEQ_CHECK_EN
    logic [15:0] seq_err_cnt;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    udp_rx_payload_reader dut (
        .gmii_rx_clk           (clk),
        .rst                   (rst),
        .udp_rec_data_valid    (valid),
        .udp_rec_data_length   (length),
        .udp_rec_ram_read_addr (addr),
        .udp_rec_ram_rdata     (rdata),
        .fifo_wr_count         (count),
        .fifo_wr_en            (wr_en),
        .fifo_wr_data          (wr_data),
        .busy                  (busy),
        .pkt_done              (pkt_done),
        .pkt_drop              (pkt_drop),
        .pkt_cnt               (pkt_cnt),
        .drop_cnt              (drop_cnt)
`ifdef UDP_RX_SEQ_CHECK_EN
        ,
        .seq_err_cnt           (seq_err_cnt)
`endif
    );

    // Receive RAM: synchronous read, data one cycle after the address.
    logic [7:0] ram [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
    end
    always @(posedge clk) rdata <= ram[addr];

    // ---------------- model: per-cycle expectations ----------------
    bit         e_wr   [NC];
    bit         e_done [NC];
    bit         e_drop [NC];
    bit         e_busy [NC];
    int         e_dinc [NC];
    int         e_addr [NC];
    logic [7:0] exp_q[$];
    int         busy_end = -1;
    int         m_pkt = 0;
    int         m_drop = 0;
    int         m_seqerr = 0;
    logic [15:0] m_seq_next = 16'd0;
    bit         m_first = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int wr_seen = 0;
    int last_done = -1;
    int last_drop = -1;
    logic [7:0] last_data = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Outcome of a valid pulse at cycle c, derived from the datagram rules.
    function automatic void launch(input int c, input int len16, input int cnt);
        int n;
        int need;
        bit drop;
        logic [15:0] s;
        if (c <= busy_end) begin
            e_dinc[c+1]++;
            return;
        end
        n    = (len16 - 8) & 'hFFFF;
        need = n - SKIP;
        drop = (len16 < MINL) || (n > 1472) || ((2048 - cnt) < need);
        if (drop) begin
            e_busy[c+1] = 1'b1;
            e_drop[c+2] = 1'b1;
            e_dinc[c+2]++;
            busy_end = c + 1;
        end else begin
            for (int k = c + 1; k <= c + n + 3; k++) e_busy[k] = 1'b1;
            for (int a = 0; a < n; a++) e_addr[c+2+a] = a;
            for (int a = SKIP; a < n; a++) begin
                e_wr[c+3+a] = 1'b1;
                exp_q.push_back(ram[a]);
            end
            e_done[c+n+3] = 1'b1;
            busy_end = c + n + 3;
            if (SKIP != 0) begin
                s = {ram[0], ram[1]};
                if (!m_first && (s != m_seq_next)) m_seqerr++;
                m_seq_next = s + 16'd1;
                m_first = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset(input int r);
        for (int k = r; k < NC; k++) begin
            e_wr[k] = 1'b0; e_done[k] = 1'b0; e_drop[k] = 1'b0;
            e_busy[k] = 1'b0; e_dinc[k] = 0; e_addr[k] = 0;
        end
        exp_q.delete();
        m_first  = 1'b1;
        m_seqerr = 0;
        busy_end = NC;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            m_pkt  = 0;
            m_drop = 0;
        end else begin
            m_pkt  += int'(e_done[cyc]);
            m_drop += e_dinc[cyc];
        end
        chk("fifo_wr_en", int'(wr_en), int'(e_wr[cyc]));
        chk("pkt_done", int'(pkt_done), int'(e_done[cyc]));
        chk("pkt_drop", int'(pkt_drop), int'(e_drop[cyc]));
        chk("busy", int'(busy), int'(e_busy[cyc]));
        chk("ram_read_addr", int'(addr), e_addr[cyc]);
        chk("pkt_cnt", int'(pkt_cnt), m_pkt & 'hFFFF);
        chk("drop_cnt", int'(drop_cnt), m_drop & 'hFFFF);
        if (rst) chk("fifo_wr_data_rst", int'(wr_data), 0);
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL fifo_wr_data at cycle %0d: got write %0d, expected no write", cyc, wr_data);
            end else begin
                chk("fifo_wr_data", int'(wr_data), int'(exp_q.pop_front()));
            end
            wr_seen++;
            last_data = wr_data;
        end
        if (pkt_done) last_done = cyc;
        if (pkt_drop) last_drop = cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int len16, input int cnt, output int c0);
        count = 12'(cnt);
        @(posedge clk); #1;
        valid  = 1'b1;
        length = 16'(len16);
        c0     = cyc;
        launch(cyc, len16, cnt);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || (cyc <= busy_end + 1)) && (guard < 4000)) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 4000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle timeout at cycle %0d: busy=%0d, expected idle", cyc, busy);
        end
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset(cyc);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        busy_end = cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int c1;
        int w0;
        int d0;
        rst    = 1'b0;
        valid  = 1'b0;
        length = 16'd0;
        count  = 12'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        busy_end = cyc;

        // Nominal 100-byte packet into an empty FIFO.
        w0 = wr_seen;
        send(108, 0, c0);
        wait_idle();
        chk("t1_writes", wr_seen - w0, EXP_N);
        chk("t1_done_cycle", last_done - c0, 103);
        chk("t1_pkt_cnt", int'(pkt_cnt), 1);
        chk("t1_last_byte", int'(last_data), 99);

        // Payload one byte over the limit.
        w0 = wr_seen;
        send(1481, 0, c0);
        wait_idle();
        chk("t2_drop_cycle", last_drop - c0, 2);
        chk("t2_writes", wr_seen - w0, 0);
        chk("t2_drop_cnt", int'(drop_cnt), 1);

        // Header-only datagram.
        send(8, 0, c0);
        wait_idle();
        chk("t3_drop_cycle", last_drop - c0, 2);
        chk("t3_drop_cnt", int'(drop_cnt), 2);

        // FIFO space boundary: 48 free drops, exactly 100 free delivers.
        send(108, 2000, c0);
        wait_idle();
        chk("t4_drop_cnt", int'(drop_cnt), 3);
        w0 = wr_seen;
        send(108, 1948, c0);
        wait_idle();
        chk("t4_pkt_cnt", int'(pkt_cnt), 2);
        chk("t4_writes", wr_seen - w0, EXP_N);

        // Second valid pulse in the middle of a packet is ignored but counted.
        w0 = wr_seen;
        d0 = last_drop;
        send(108, 0, c0);
        goto_cycle(c0 + 49);
        send(108, 0, c1);
        wait_idle();
        chk("t5_ignored_cycle", c1 - c0, 50);
        chk("t5_pkt_cnt", int'(pkt_cnt), 3);
        chk("t5_drop_cnt", int'(drop_cnt), 4);
        chk("t5_writes", wr_seen - w0, EXP_N);
        chk("t5_no_drop_pulse", last_drop, d0);

        // Reset in the middle of a packet, then a clean packet.
        send(108, 0, c0);
        goto_cycle(c0 + 39);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset(cyc);
        #1;
        chk("t6_wr_en_in_reset", int'(wr_en), 0);
        chk("t6_busy_in_reset", int'(busy), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        busy_end = cyc;
        w0 = wr_seen;
        send(108, 0, c0);
        wait_idle();
        chk("t6_pkt_cnt", int'(pkt_cnt), 1);
        chk("t6_drop_cnt", int'(drop_cnt), 0);
        chk("t6_writes", wr_seen - w0, EXP_N);

`ifdef UDP_RX_SEQ_CHECK_EN
        // Sequence numbers 5, 6, 8, 9, then 0xFFFF, 0x0000.
        begin
            int seqs [6];
            seqs = '{5, 6, 8, 9, 'hFFFF, 0};
            do_reset();
            for (int i = 0; i < 6; i++) begin
                ram[0] = 8'(seqs[i] >> 8);
                ram[1] = 8'(seqs[i]);
                w0 = wr_seen;
                send(108, 0, c0);
                wait_idle();
                chk("t7_writes", wr_seen - w0, 98);
                chk("t7_seq_err_model", int'(seq_err_cnt), m_seqerr);
                if (i == 3) chk("t7_seq_err_after_9", int'(seq_err_cnt), 1);
            end
            chk("t7_seq_err_wrap", int'(seq_err_cnt), 2);
        end
`else
        do_reset();
        chk("t7_pkt_cnt_after_reset", int'(pkt_cnt), 0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
